mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  Memory stage of the PLP pipeline, directly upstream of the writeback mux.
//  Executes LW/LBU/SW/SB over a single-master req/ack data bus and stalls the pipeline while busy.
//  Delivers data_word and lbu_byte to writeback, plus a one-cycle wb_valid/mem_err completion strobe.
//  Implements SB as a read-modify-write sequence, since the bus has no byte enables.
// PARAMETERS
//  TIMEOUT   255   bus cycles without ack before the access is aborted with mem_err (must be >=1)
// PORTS
//  clk         in   1        system clock; all state updates on rising edge
//  rst_n       in   1        synchronous reset, active-low
//  c_mem_op    in   3        MEM_NONE=0, MEM_LW=1, MEM_LBU=2, MEM_SW=3, MEM_SB=4; 5-7 treated as MEM_NONE
//  addr        in   W_DATA   byte address (ALU result)
//  store_data  in   W_DATA   rt value; SB uses bits [7:0]
//  stall       out  1        holds upstream stages
//  bus_req     out  1        bus request
//  bus_we      out  1        1 = write
//  bus_addr    out  W_DATA   word address, {addr[W_DATA-1:2],2'b00}
//  bus_wdata   out  W_DATA   write data
//  bus_rdata   in   W_DATA   read data, valid when bus_ack
//  bus_ack     in   1        completes the current request (one-cycle pulse)
//  data_word   out  W_DATA   loaded word to writeback
//  lbu_byte    out  2        byte lane for LBU (= addr[1:0]), lane 0 = bits [7:0]
//  wb_valid    out  1        one-cycle completion strobe (loads and stores)
//  mem_err     out  1        one-cycle strobe coincident with wb_valid: misaligned access or timeout
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): state IDLE; all registered outputs and counters 0.
//    Reset mid-access drops bus_req at that edge. No wb_valid is produced for an aborted access.
//  - States:
//    IDLE: c_mem_op != NONE -> latch op/addr/store_data; LW/SW with addr[1:0]!=0 -> DONE with err.
//          Otherwise LW/LBU/SB -> RD, SW -> WR.
//    RD: bus_req=1, bus_we=0. On ack: capture bus_rdata; LW/LBU -> DONE; SB -> WR with merged word.
//    WR: bus_req=1, bus_we=1. On ack -> DONE.
//    DONE: wb_valid=1 (mem_err if flagged) -> IDLE.
//  - stall is combinational: 1 when (IDLE and op != NONE), RD or WR; 0 in DONE and in IDLE with op NONE.
//    The upstream instruction advances on the DONE cycle, and the next op is sampled in IDLE.
//  - Minimum latency, op presented to wb_valid: LW/LBU/SW 2 cycles (ack on the first request cycle); SB 3 cycles.
//  - SB merge: bus_wdata = read word with lane addr[1:0] replaced by store_data[7:0]; other lanes unchanged.
//  - bus_req, bus_we, bus_addr and bus_wdata are registered and stable while a request is outstanding.
//    They drop the cycle after ack.
//  - bus_ack outside RD/WR is ignored. An ack coincident with the timeout edge counts as success.
//  - Timeout: counter clears on entering RD/WR, increments each cycle without ack.
//    At TIMEOUT the access aborts -> DONE with mem_err=1, data_word=0, and the SB write phase is skipped.
//  - data_word and lbu_byte hold their values until the next load completes; stores leave them unchanged.
//  - Misaligned LW/SW issue no bus cycle, and data_word is unchanged.
// STRUCTURE
//  - MEM_* op codes, state encodings and ZERO_DATA go in constant_params.vh; W_DATA comes from constant_defs.vh.
//  - One sub-module, byte_merge (combinational lane insert: word, byte, lane -> word).
//  - The FSM and timeout counter stay in mem_access.
// TESTING
//  - LW at 0x104, ack on the first request cycle with rdata=0xDEADBEEF:
//    bus_addr=0x104, data_word=0xDEADBEEF, wb_valid 2 cycles after the op, stall high for exactly 2 cycles.
//  - LBU at 0x206 with rdata=0x11223344: bus_addr=0x204, lbu_byte=2, data_word=0x11223344.
//  - SB 0xAA to 0x301, read returns 0x11223344: second bus cycle is a write with wdata=0x1122AA44, wb_valid at cycle 3.
//  - SW at 0x102: no bus_req, wb_valid=1 and mem_err=1 one cycle after the op.
//  - LW with ack withheld and TIMEOUT=4: bus_req high 4 cycles then low, mem_err=1, data_word=0, stall released.
//  - rst_n low during WR of an SB: bus_req=0 after that edge, no wb_valid; the next LW after reset completes normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants for the PLP memory stage: op codes, FSM state encodings and data width.
// Also holds small decode helpers used by the stage and its byte-merge sub-block.
package mem_access_pkg;

  localparam int W_DATA = 32;

  localparam logic [2:0] MEM_NONE = 3'd0;
  localparam logic [2:0] MEM_LW   = 3'd1;
  localparam logic [2:0] MEM_LBU  = 3'd2;
  localparam logic [2:0] MEM_SW   = 3'd3;
  localparam logic [2:0] MEM_SB   = 3'd4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [W_DATA-1:0] ZERO_DATA = '0;

  // Codes 5-7 behave exactly like MEM_NONE.
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op != MEM_NONE) && (op <= MEM_SB);
  endfunction

  function automatic logic [W_DATA-1:0] word_addr(input logic [W_DATA-1:0] a);
    return {a[W_DATA-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_byte_merge.sv
// Combinational lane insert: replaces one byte lane of a word (lane 0 = bits [7:0]).
module mem_access_byte_merge
  import mem_access_pkg::*;
(
  input  logic [W_DATA-1:0] i_word,
  input  logic [7:0]        i_byte,
  input  logic [1:0]        i_lane,
  output logic [W_DATA-1:0] o_word
);

  always_comb begin
    o_word = i_word;
    case (i_lane)
      2'd0: o_word[7:0]   = i_byte;
      2'd1: o_word[15:8]  = i_byte;
      2'd2: o_word[23:16] = i_byte;
      2'd3: o_word[31:24] = i_byte;
      default: o_word = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// PLP memory stage: LW/LBU/SW/SB over a req/ack bus, SB as read-modify-write, stalls upstream while busy.
// Best case op-to-wb_valid: 2 cycles (LW/LBU/SW), 3 cycles (SB); a silent bus aborts after TIMEOUT cycles.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        c_mem_op,
  input  logic [W_DATA-1:0] addr,
  input  logic [W_DATA-1:0] store_data,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [W_DATA-1:0] bus_addr,
  output logic [W_DATA-1:0] bus_wdata,
  input  logic [W_DATA-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic [W_DATA-1:0] data_word,
  output logic [1:0]        lbu_byte,
  output logic              wb_valid,
  output logic              mem_err
);

  localparam int W_CNT = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [2:0]        r_op;
  logic [1:0]        r_lane;
  logic [7:0]        r_sbyte;
  logic              r_err;
  logic [W_CNT-1:0]  r_cnt;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [W_DATA-1:0] r_bus_addr;
  logic [W_DATA-1:0] r_bus_wdata;
  logic [W_DATA-1:0] r_data_word;
  logic [1:0]        r_lbu_byte;
  logic [W_DATA-1:0] w_merged;
  logic              w_is_load;

  mem_access_byte_merge u_byte_merge (
    .i_word (bus_rdata),
    .i_byte (r_sbyte),
    .i_lane (r_lane),
    .o_word (w_merged)
  );

  assign w_is_load = (r_op == MEM_LW) || (r_op == MEM_LBU);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= MEM_NONE;
      r_lane      <= 2'd0;
      r_sbyte     <= 8'd0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= ZERO_DATA;
      r_bus_wdata <= ZERO_DATA;
      r_data_word <= ZERO_DATA;
      r_lbu_byte  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (is_mem_op(c_mem_op)) begin
            r_op    <= c_mem_op;
            r_lane  <= addr[1:0];
            r_sbyte <= store_data[7:0];
            r_cnt   <= '0;
            r_err   <= 1'b0;
            if ((c_mem_op == MEM_LW || c_mem_op == MEM_SW) && addr[1:0] != 2'd0) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_bus_req  <= 1'b1;
              r_bus_addr <= word_addr(addr);
              if (c_mem_op == MEM_SW) begin
                r_bus_we    <= 1'b1;
                r_bus_wdata <= store_data;
                r_state     <= S_WR;
              end else begin
                r_bus_we <= 1'b0;
                r_state  <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (bus_ack) begin
            r_cnt <= '0;
            if (r_op == MEM_SB) begin
              // Request stays up: the write phase follows the read without a gap.
              r_bus_we    <= 1'b1;
              r_bus_wdata <= w_merged;
              r_state     <= S_WR;
            end else begin
              r_bus_req   <= 1'b0;
              r_data_word <= bus_rdata;
              r_lbu_byte  <= r_lane;
              r_state     <= S_DONE;
            end
          end else if (r_cnt == CNT_LAST) begin
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= S_DONE;
            if (w_is_load) begin
              r_data_word <= ZERO_DATA;
              r_lbu_byte  <= r_lane;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WR: begin
          if (bus_ack) begin
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall     = ((r_state == S_IDLE) && is_mem_op(c_mem_op)) ||
                     (r_state == S_RD) || (r_state == S_WR);
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign data_word = r_data_word;
  assign lbu_byte  = r_lbu_byte;
  assign wb_valid  = (r_state == S_DONE);
  assign mem_err   = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized ops against a word-memory model.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TO = 4;

  logic        clk, rst_n;
  logic [2:0]  c_mem_op;
  logic [31:0] addr, store_data;
  logic        stall, bus_req, bus_we, bus_ack, wb_valid, mem_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, data_word;
  logic [1:0]  lbu_byte;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .c_mem_op(c_mem_op), .addr(addr), .store_data(store_data),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .data_word(data_word), .lbu_byte(lbu_byte), .wb_valid(wb_valid), .mem_err(mem_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] wr_a_q[$];
  logic [31:0] wr_d_q[$];
  int          n_rd;
  int          ack_delay;
  bit          hold_rd, hold_wr, force_ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [7:0] b,
                                           input logic [1:0] lane);
    logic [31:0] mask;
    mask = 32'hFF << (8 * lane);
    return (w & ~mask) | ({24'd0, b} << (8 * lane));
  endfunction

  // Bus slave: acks after ack_delay request cycles, backed by the word memory.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus_ack = 1'b0;
      if (bus_req) begin
        if ((bus_we ? hold_wr : hold_rd) || wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          bus_ack  = 1'b1;
          wait_cnt = 0;
          if (bus_we) begin
            mem[bus_addr] = bus_wdata;
            wr_a_q.push_back(bus_addr);
            wr_d_q.push_back(bus_wdata);
          end else begin
            bus_rdata = mem_get(bus_addr);
            n_rd++;
          end
        end
      end else begin
        wait_cnt = 0;
        if (force_ack) bus_ack = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  // Presents one op (called at posedge+1), follows upstream stall handshake until wb_valid.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] sd,
                        output int lat, output bit err, output int stall_n, output int req_n,
                        output logic [31:0] first_addr, output bit got);
    bit done;
    int cyc;
    bit st;
    done = 0; cyc = 0;
    lat = -1; err = 0; stall_n = 0; req_n = 0; first_addr = '0; got = 0;
    wr_a_q.delete(); wr_d_q.delete(); n_rd = 0;
    c_mem_op = op; addr = a; store_data = sd;
    while (!done && cyc < 40) begin
      @(negedge clk);
      st = stall;
      if (stall) stall_n++;
      if (bus_req) begin
        if (req_n == 0) first_addr = bus_addr;
        req_n++;
      end
      if (wb_valid) begin
        done = 1; got = 1; lat = cyc; err = mem_err;
      end
      cyc++;
      @(posedge clk);
      #1;
      if (!st) c_mem_op = MEM_NONE;
    end
    c_mem_op = MEM_NONE;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; c_mem_op = MEM_NONE; addr = '0; store_data = '0;
    hold_rd = 0; hold_wr = 0; force_ack = 0; ack_delay = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus_req, bus_we, wb_valid, mem_err, stall} !== 5'b0)
      $display("FAIL reset_ctl: got req/we/wb/err/stall=%b required 00000",
               {bus_req, bus_we, wb_valid, mem_err, stall});
    else n_pass++;
    n_checks++;
    if (bus_addr !== 32'h0 || bus_wdata !== 32'h0)
      $display("FAIL reset_bus: got addr=%h wdata=%h required 0", bus_addr, bus_wdata);
    else n_pass++;
    n_checks++;
    if (data_word !== 32'h0 || lbu_byte !== 2'd0)
      $display("FAIL reset_wb: got data_word=%h lbu_byte=%0d required 0", data_word, lbu_byte);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_lw();
    int lat, sn, rn; bit err, got; logic [31:0] fa;
    mem[32'h104] = 32'hDEADBEEF; ack_delay = 0;
    run_op(MEM_LW, 32'h104, 32'h0, lat, err, sn, rn, fa, got);
    n_checks++;
    if (!got || lat != 2 || err !== 1'b0)
      $display("FAIL lw_latency: got valid=%0d lat=%0d err=%0d required 1/2/0", got, lat, err);
    else n_pass++;
    n_checks++;
    if (sn != 2) $display("FAIL lw_stall: got %0d stall cycles required 2", sn);
    else n_pass++;
    n_checks++;
    if (fa !== 32'h104 || rn != 1)
      $display("FAIL lw_bus: got addr=%h req_cycles=%0d required 104/1", fa, rn);
    else n_pass++;
    n_checks++;
    if (data_word !== 32'hDEADBEEF)
      $display("FAIL lw_data: got %h required deadbeef", data_word);
    else n_pass++;
  endtask

  task automatic test_lbu();
    int lat, sn, rn; bit err, got; logic [31:0] fa;
    mem[32'h204] = 32'h11223344; ack_delay = 0;
    run_op(MEM_LBU, 32'h206, 32'h0, lat, err, sn, rn, fa, got);
    n_checks++;
    if (fa !== 32'h204) $display("FAIL lbu_addr: got %h required 204", fa);
    else n_pass++;
    n_checks++;
    if (data_word !== 32'h11223344 || lbu_byte !== 2'd2)
      $display("FAIL lbu_data: got word=%h lane=%0d required 11223344/2", data_word, lbu_byte);
    else n_pass++;
    n_checks++;
    if (!got || lat != 2) $display("FAIL lbu_latency: got %0d required 2", lat);
    else n_pass++;
  endtask

  task automatic test_sb();
    int lat, sn, rn; bit err, got; logic [31:0] fa;
    mem[32'h300] = 32'h11223344; ack_delay = 0;
    run_op(MEM_SB, 32'h301, 32'h123456AA, lat, err, sn, rn, fa, got);
    n_checks++;
    if (!got || lat != 3 || err !== 1'b0)
      $display("FAIL sb_latency: got valid=%0d lat=%0d err=%0d required 1/3/0", got, lat, err);
    else n_pass++;
    n_checks++;
    if (n_rd != 1 || wr_a_q.size() != 1)
      $display("FAIL sb_cycles: got reads=%0d writes=%0d required 1/1", n_rd, wr_a_q.size());
    else n_pass++;
    if (wr_a_q.size() == 1) begin
      n_checks++;
      if (wr_a_q[0] !== 32'h300 || wr_d_q[0] !== 32'h1122AA44)
        $display("FAIL sb_write: got addr=%h wdata=%h required 300/1122aa44", wr_a_q[0], wr_d_q[0]);
      else n_pass++;
    end
    n_checks++;
    if (data_word !== 32'h11223344 || lbu_byte !== 2'd2)
      $display("FAIL sb_keeps_wb: got word=%h lane=%0d required 11223344/2", data_word, lbu_byte);
    else n_pass++;
  endtask

  task automatic test_sw_misaligned();
    int lat, sn, rn; bit err, got; logic [31:0] fa;
    run_op(MEM_SW, 32'h102, 32'h55667788, lat, err, sn, rn, fa, got);
    n_checks++;
    if (!got || lat != 1 || err !== 1'b1)
      $display("FAIL sw_mis_err: got valid=%0d lat=%0d err=%0d required 1/1/1", got, lat, err);
    else n_pass++;
    n_checks++;
    if (rn != 0 || wr_a_q.size() != 0)
      $display("FAIL sw_mis_bus: got req_cycles=%0d writes=%0d required 0/0", rn, wr_a_q.size());
    else n_pass++;
    n_checks++;
    if (data_word !== 32'h11223344) $display("FAIL sw_mis_data: got %h required 11223344", data_word);
    else n_pass++;
  endtask

  task automatic test_spurious_ack();
    force_ack = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({wb_valid, bus_req, stall} !== 3'b0)
        $display("FAIL idle_ack: got wb/req/stall=%b required 000", {wb_valid, bus_req, stall});
      else n_pass++;
      @(posedge clk);
      #1;
    end
    force_ack = 0;
  endtask

  task automatic test_timeout();
    int lat, sn, rn; bit err, got; logic [31:0] fa;
    hold_rd = 1;
    run_op(MEM_LW, 32'h500, 32'h0, lat, err, sn, rn, fa, got);
    hold_rd = 0;
    n_checks++;
    if (!got || lat != TO + 1 || err !== 1'b1)
      $display("FAIL timeout_err: got valid=%0d lat=%0d err=%0d required 1/%0d/1", got, lat, err, TO + 1);
    else n_pass++;
    n_checks++;
    if (rn != TO) $display("FAIL timeout_req: got %0d req cycles required %0d", rn, TO);
    else n_pass++;
    n_checks++;
    if (data_word !== 32'h0) $display("FAIL timeout_data: got %h required 0", data_word);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || bus_req !== 1'b0)
      $display("FAIL timeout_release: got stall=%b req=%b required 0/0", stall, bus_req);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ack_at_timeout();
    int lat, sn, rn; bit err, got; logic [31:0] fa;
    mem[32'h504] = 32'hA5A55A5A; ack_delay = TO - 1;
    run_op(MEM_LW, 32'h504, 32'h0, lat, err, sn, rn, fa, got);
    ack_delay = 0;
    n_checks++;
    if (!got || lat != TO + 1 || err !== 1'b0 || data_word !== 32'hA5A55A5A)
      $display("FAIL ack_at_timeout: got lat=%0d err=%0d word=%h required %0d/0/a5a55a5a",
               lat, err, data_word, TO + 1);
    else n_pass++;
  endtask

  task automatic test_reset_mid_sb();
    int cyc, lat, sn, rn; bit err, got, saw_wb; logic [31:0] fa;
    cyc = 0; saw_wb = 0;
    mem[32'h400] = 32'hCAFEF00D; hold_wr = 1; ack_delay = 0;
    wr_a_q.delete(); wr_d_q.delete();
    c_mem_op = MEM_SB; addr = 32'h402; store_data = 32'h55;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(bus_req && bus_we) && cyc < 10);
    n_checks++;
    if (!(bus_req && bus_we)) $display("FAIL rst_sb_wr_phase: got req=%b we=%b required 1/1", bus_req, bus_we);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus_req !== 1'b0 || wb_valid !== 1'b0 || data_word !== 32'h0)
      $display("FAIL rst_mid_access: got req=%b wb=%b word=%h required 0/0/0", bus_req, wb_valid, data_word);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1; c_mem_op = MEM_NONE; hold_wr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_valid) saw_wb = 1;
    end
    n_checks++;
    if (saw_wb || wr_a_q.size() != 0)
      $display("FAIL rst_no_wb: got wb_seen=%0d writes=%0d required 0/0", saw_wb, wr_a_q.size());
    else n_pass++;
    @(posedge clk);
    #1;
    run_op(MEM_LW, 32'h400, 32'h0, lat, err, sn, rn, fa, got);
    n_checks++;
    if (!got || lat != 2 || err !== 1'b0 || data_word !== 32'hCAFEF00D)
      $display("FAIL rst_then_lw: got lat=%0d err=%0d word=%h required 2/0/cafef00d", lat, err, data_word);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [1:0]  lane, m_lane;
    logic [31:0] wa, sd, old, e_wd, fa, m_dw;
    int d, e_lat, e_rd, e_wr, r, lat, sn, rn;
    bit mis, err, got;
    m_dw = '0; m_lane = '0; e_wd = '0;
    for (int i = 0; i < 80; i++) begin
      r    = $urandom_range(0, 9);
      op   = (i == 0) ? MEM_LW : (r < 8) ? 3'(1 + r % 4) : (r == 8) ? MEM_NONE : 3'(5 + $urandom_range(0, 2));
      wa   = 32'h1000 + 32'(4 * $urandom_range(0, 7));
      lane = (i == 0 || $urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      sd   = $urandom;
      d    = $urandom_range(0, TO - 1);
      ack_delay = d;
      if (op == MEM_NONE || op > MEM_SB) begin
        c_mem_op = op; addr = wa | {30'd0, lane};
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          n_checks++;
          if ({stall, bus_req, wb_valid} !== 3'b0)
            $display("FAIL rnd_none[%0d]: op=%0d got stall/req/wb=%b required 000", i, op,
                     {stall, bus_req, wb_valid});
          else n_pass++;
          @(posedge clk);
          #1;
        end
        c_mem_op = MEM_NONE;
        continue;
      end
      mis = (op == MEM_LW || op == MEM_SW) && lane != 2'd0;
      old = mem_get(wa);
      e_rd = 0; e_wr = 0;
      if (mis) e_lat = 1;
      else if (op == MEM_LW || op == MEM_LBU) begin
        e_lat = 2 + d; e_rd = 1; m_dw = old; m_lane = lane;
      end else if (op == MEM_SW) begin
        e_lat = 2 + d; e_wr = 1; e_wd = sd;
      end else begin
        e_lat = 3 + 2 * d; e_rd = 1; e_wr = 1; e_wd = put_byte(old, sd[7:0], lane);
      end
      run_op(op, wa | {30'd0, lane}, sd, lat, err, sn, rn, fa, got);
      n_checks++;
      if (!got || lat != e_lat || err !== mis || sn != e_lat)
        $display("FAIL rnd_timing[%0d]: op=%0d got lat=%0d err=%0d stall=%0d required %0d/%0d/%0d",
                 i, op, lat, err, sn, e_lat, mis, e_lat);
      else n_pass++;
      n_checks++;
      if (n_rd != e_rd || wr_a_q.size() != e_wr)
        $display("FAIL rnd_cycles[%0d]: op=%0d got reads=%0d writes=%0d required %0d/%0d",
                 i, op, n_rd, wr_a_q.size(), e_rd, e_wr);
      else n_pass++;
      if (e_wr == 1 && wr_a_q.size() == 1) begin
        n_checks++;
        if (wr_a_q[0] !== wa || wr_d_q[0] !== e_wd)
          $display("FAIL rnd_write[%0d]: got addr=%h wdata=%h required %h/%h", i, wr_a_q[0], wr_d_q[0], wa, e_wd);
        else n_pass++;
      end
      if (!mis) begin
        n_checks++;
        if (fa !== wa) $display("FAIL rnd_addr[%0d]: got %h required %h", i, fa, wa);
        else n_pass++;
      end
      n_checks++;
      if (data_word !== m_dw || lbu_byte !== m_lane)
        $display("FAIL rnd_wb[%0d]: got word=%h lane=%0d required %h/%0d", i, data_word, lbu_byte, m_dw, m_lane);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lbu();
    test_sb();
    test_sw_misaligned();
    test_spurious_ack();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_sb();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
